// File: rtl/tjmono2_rx_arbiter.sv
// rtl/tjmono2_rx_arbiter.sv - merges NLANES first-word-fall-through lane FIFOs into one tagged 32-bit output stream
module tjmono2_rx_arbiter #(
    parameter int NLANES          = 4,
    parameter int ABUSWIDTH       = 32,
    parameter int DATA_IDENTIFIER = 0,
    parameter int VERSION         = 2
) (
    input  logic                   BUS_CLK,
    input  logic                   RST,
    input  logic [ABUSWIDTH-1:0]   BUS_ADD,
    input  logic [7:0]             BUS_DATA_IN,
    output logic [7:0]             BUS_DATA_OUT,
    input  logic                   BUS_WR,
    input  logic                   BUS_RD,
    input  logic [NLANES*28-1:0]   LANE_DATA,
    input  logic [NLANES-1:0]      LANE_EMPTY,
    output logic [NLANES-1:0]      LANE_READ,
    input  logic [NLANES-1:0]      LANE_DEC_ERR,
    input  logic [NLANES-1:0]      LANE_LOST_ERR,
    output logic [31:0]            FIFO_DATA,
    output logic                   FIFO_EMPTY,
    input  logic                   FIFO_READ
);

    localparam int              LW        = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [3:0]      ID_BASE   = 4'(DATA_IDENTIFIER);
    localparam logic [LW-1:0]   LAST_LANE = LW'(NLANES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic            rst_int;
    logic [7:0]      lane_en;
    logic            mode;
    logic [7:0]      burst;
    logic [7:0]      burst_lim;
    logic [7:0]      burst_cnt;
    logic [LW-1:0]   grant;
    logic [LW-1:0]   last_granted;
    logic [LW-1:0]   sel;
    logic [NLANES-1:0] eligible;
    logic            pop;
    logic [27:0]     lane_word;
    logic [31:0]     fifo_data;
    logic            fifo_empty;
    logic [31:0]     word_cnt;
    logic [31:0]     cnt_buf;
    logic [7:0]      dec_cnt  [NLANES];
    logic [7:0]      lost_cnt [NLANES];
    logic [7:0]      not_empty;
    logic [7:0]      rd_mux;

    // A write to address 0 acts as a soft reset of the whole block
    assign rst_int   = RST | (BUS_WR && (BUS_ADD == ABUSWIDTH'(0)));
    assign eligible  = lane_en[NLANES-1:0] & ~LANE_EMPTY;
    assign burst_lim = (burst == 8'd0) ? 8'd1 : burst;
    assign FIFO_DATA  = fifo_data;
    assign FIFO_EMPTY = fifo_empty;

    // Configuration registers
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            lane_en <= 8'd0;
            mode    <= 1'b0;
            burst   <= 8'd8;
        end else if (BUS_WR) begin
            if (BUS_ADD == ABUSWIDTH'(1)) lane_en <= BUS_DATA_IN;
            if (BUS_ADD == ABUSWIDTH'(2)) mode    <= BUS_DATA_IN[0];
            if (BUS_ADD == ABUSWIDTH'(3)) burst   <= BUS_DATA_IN;
        end
    end

    // Next lane to serve: rotating search after the last grant, or lowest index in fixed mode
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        sel   = last_granted;
        for (int k = 1; k <= NLANES; k++) begin
            if (mode) idx = k - 1;
            else      idx = (int'(last_granted) + k) % NLANES;
            if (!found && eligible[LW'(idx)]) begin
                found = 1'b1;
                sel   = LW'(idx);
            end
        end
    end

    // Word presented by the granted lane
    always_comb begin
        lane_word = 28'd0;
        for (int i = 0; i < NLANES; i++) begin
            if (grant == LW'(i)) lane_word = LANE_DATA[28*i +: 28];
        end
    end

    // FSM state register
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next state and pop decision; a pop needs room in the output register
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) state_nxt = GRANT;
            end
            GRANT: begin
                if (!eligible[grant]) begin
                    state_nxt = IDLE;
                end else if (fifo_empty || FIFO_READ) begin
                    pop = 1'b1;
                    if (burst_cnt == burst_lim - 8'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst_int) pop = 1'b0;
    end

    // One-hot pop strobe towards the granted lane
    always_comb begin
        LANE_READ = '0;
        if (pop) LANE_READ[grant] = 1'b1;
    end

    // Grant bookkeeping, output register and forwarded-word counter
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            grant        <= '0;
            last_granted <= LAST_LANE;
            burst_cnt    <= 8'd0;
            fifo_data    <= 32'd0;
            fifo_empty   <= 1'b1;
            word_cnt     <= 32'd0;
        end else begin
            if (state == IDLE && (|eligible)) begin
                grant        <= sel;
                last_granted <= sel;
                burst_cnt    <= 8'd0;
            end
            if (pop) begin
                fifo_data  <= {ID_BASE + 4'(grant), lane_word};
                fifo_empty <= 1'b0;
                burst_cnt  <= burst_cnt + 8'd1;
                word_cnt   <= word_cnt + 32'd1;
            end else if (FIFO_READ && !fifo_empty) begin
                fifo_empty <= 1'b1;
            end
        end
    end

    // Saturating per-lane error counters; a bus write to a counter clears it and beats a pulse
    always_ff @(posedge BUS_CLK) begin
        for (int i = 0; i < NLANES; i++) begin
            if (rst_int) begin
                dec_cnt[i]  <= 8'd0;
                lost_cnt[i] <= 8'd0;
            end else begin
                if (BUS_WR && (BUS_ADD == ABUSWIDTH'(16 + i)))
                    dec_cnt[i] <= 8'd0;
                else if (LANE_DEC_ERR[i] && dec_cnt[i] != 8'hFF)
                    dec_cnt[i] <= dec_cnt[i] + 8'd1;
                if (BUS_WR && (BUS_ADD == ABUSWIDTH'(32 + i)))
                    lost_cnt[i] <= 8'd0;
                else if (LANE_LOST_ERR[i] && lost_cnt[i] != 8'hFF)
                    lost_cnt[i] <= lost_cnt[i] + 8'd1;
            end
        end
    end

    // Register read multiplexer
    always_comb begin
        not_empty = 8'd0;
        not_empty[NLANES-1:0] = ~LANE_EMPTY;
        rd_mux = 8'd0;
        if (BUS_ADD == ABUSWIDTH'(0)) rd_mux = 8'(VERSION);
        if (BUS_ADD == ABUSWIDTH'(1)) rd_mux = lane_en;
        if (BUS_ADD == ABUSWIDTH'(2)) rd_mux = {7'd0, mode};
        if (BUS_ADD == ABUSWIDTH'(3)) rd_mux = burst;
        if (BUS_ADD == ABUSWIDTH'(4)) rd_mux = word_cnt[7:0];
        if (BUS_ADD == ABUSWIDTH'(5)) rd_mux = cnt_buf[15:8];
        if (BUS_ADD == ABUSWIDTH'(6)) rd_mux = cnt_buf[23:16];
        if (BUS_ADD == ABUSWIDTH'(7)) rd_mux = cnt_buf[31:24];
        if (BUS_ADD == ABUSWIDTH'(8)) rd_mux = not_empty;
        for (int i = 0; i < NLANES; i++) begin
            if (BUS_ADD == ABUSWIDTH'(16 + i)) rd_mux = dec_cnt[i];
            if (BUS_ADD == ABUSWIDTH'(32 + i)) rd_mux = lost_cnt[i];
        end
    end

    // Registered read data; reading byte 0 freezes the counter so bytes 1..3 stay coherent
    always_ff @(posedge BUS_CLK) begin
        if (rst_int) begin
            BUS_DATA_OUT <= 8'd0;
            cnt_buf      <= 32'd0;
        end else if (BUS_RD) begin
            BUS_DATA_OUT <= rd_mux;
            if (BUS_ADD == ABUSWIDTH'(4)) cnt_buf <= word_cnt;
        end
    end

endmodule

// File: tb/tb_tjmono2_rx_arbiter.sv
// tb/tb_tjmono2_rx_arbiter.sv - scoreboard bench for tjmono2_rx_arbiter
module tb_tjmono2_rx_arbiter;

    localparam int NL = 4;

    logic              BUS_CLK;
    logic              RST;
    logic [31:0]       BUS_ADD;
    logic [7:0]        BUS_DATA_IN;
    logic [7:0]        BUS_DATA_OUT;
    logic              BUS_WR;
    logic              BUS_RD;
    logic [NL*28-1:0]  LANE_DATA;
    logic [NL-1:0]     LANE_EMPTY;
    logic [NL-1:0]     LANE_READ;
    logic [NL-1:0]     LANE_DEC_ERR;
    logic [NL-1:0]     LANE_LOST_ERR;
    logic [31:0]       FIFO_DATA;
    logic              FIFO_EMPTY;
    logic              FIFO_READ;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q [$];
    logic [7:0]  bus_q [$];
    logic        rd_pend = 1'b0;

    logic [27:0] lmem [NL][128];
    int          lhead [NL] = '{default: 0};
    int          ltail [NL] = '{default: 0};
    int          flush_seq  = 0;
    int          flush_seen = 0;
    int          lane_reads = 0;
    logic [NL-1:0] lr_s;

    tjmono2_rx_arbiter #(
        .NLANES(NL), .ABUSWIDTH(32), .DATA_IDENTIFIER(0), .VERSION(2)
    ) dut (
        .BUS_CLK(BUS_CLK), .RST(RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
        .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD),
        .LANE_DATA(LANE_DATA), .LANE_EMPTY(LANE_EMPTY), .LANE_READ(LANE_READ),
        .LANE_DEC_ERR(LANE_DEC_ERR), .LANE_LOST_ERR(LANE_LOST_ERR),
        .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_READ(FIFO_READ)
    );

    initial begin
        BUS_CLK = 1'b0;
        forever #5 BUS_CLK = ~BUS_CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int lane, input int k);
        return {4'(lane), 4'(lane), 24'(k)};
    endfunction

    task automatic push_lane(input int lane, input int k);
        lmem[lane][ltail[lane]] = {4'(lane), 24'(k)};
        ltail[lane]++;
    endtask

    task automatic bus_wr(input int addr, input logic [7:0] data);
        @(posedge BUS_CLK); #1;
        BUS_WR = 1'b1; BUS_ADD = 32'(addr); BUS_DATA_IN = data;
        @(posedge BUS_CLK); #1;
        BUS_WR = 1'b0;
    endtask

    task automatic bus_rd(input int addr, input logic [7:0] exp);
        @(posedge BUS_CLK); #1;
        BUS_RD = 1'b1; BUS_ADD = 32'(addr);
        bus_q.push_back(exp);
        @(posedge BUS_CLK); #1;
        BUS_RD = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge BUS_CLK); #1;
        RST = 1'b1;
        flush_seq++;
        repeat (3) @(posedge BUS_CLK);
        #1 RST = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(posedge BUS_CLK);
            n++;
        end
        check(name, sb_q.size(), 0);
        repeat (4) @(posedge BUS_CLK);
        #1;
    endtask

    // Lane FIFO model: pops sampled at negedge are applied just after the next rising edge
    initial begin
        LANE_EMPTY = '1;
        LANE_DATA  = '0;
        forever begin
            @(negedge BUS_CLK);
            lr_s = LANE_READ;
            if (LANE_READ != '0) begin
                lane_reads++;
                check("lane_read_onehot", 32'($countones(LANE_READ)), 32'd1);
            end
            @(posedge BUS_CLK); #1;
            if (flush_seen != flush_seq) begin
                flush_seen = flush_seq;
                for (int i = 0; i < NL; i++) lhead[i] = ltail[i];
            end else begin
                for (int i = 0; i < NL; i++)
                    if (lr_s[i] && lhead[i] != ltail[i]) lhead[i]++;
            end
            for (int i = 0; i < NL; i++) begin
                LANE_EMPTY[i] = (lhead[i] == ltail[i]);
                LANE_DATA[28*i +: 28] = lmem[i][lhead[i]];
            end
        end
    end

    // Monitor: compares consumed output words and bus read data against the expected queues
    initial begin
        forever begin
            @(negedge BUS_CLK);
            if (rd_pend) begin
                if (bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_rd_unexpected actual=0x%0h expected=none", BUS_DATA_OUT);
                end else begin
                    check("bus_rd", 32'(BUS_DATA_OUT), 32'(bus_q.pop_front()));
                end
                rd_pend = 1'b0;
            end
            if (BUS_RD) rd_pend = 1'b1;
            if (FIFO_READ && !FIFO_EMPTY) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_unexpected_word actual=0x%0h expected=none", FIFO_DATA);
                end else begin
                    check("sb_word", FIFO_DATA, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int base;
        logic [31:0] held;
        RST = 1'b1; BUS_ADD = '0; BUS_DATA_IN = '0; BUS_WR = 1'b0; BUS_RD = 1'b0;
        LANE_DEC_ERR = '0; LANE_LOST_ERR = '0; FIFO_READ = 1'b0;

        // Reset values
        do_reset();
        check("rst_fifo_empty", 32'(FIFO_EMPTY), 32'd1);
        check("rst_fifo_data", FIFO_DATA, 32'd0);
        check("rst_lane_read", 32'(LANE_READ), 32'd0);
        bus_rd(0, 8'h02);
        bus_rd(1, 8'h00);
        bus_rd(2, 8'h00);
        bus_rd(3, 8'h08);
        bus_rd(9, 8'h00);

        // Round-robin fairness, burst 2
        do_reset();
        bus_wr(3, 8'd2);
        FIFO_READ = 1'b1;
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < 4; k++) push_lane(i, k);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NL; i++)
                for (int k = 0; k < 2; k++) sb_q.push_back(exp_word(i, 2*r + k));
        repeat (3) @(posedge BUS_CLK);
        base = lane_reads;
        bus_wr(1, 8'h0F);
        wait_drain("rr_drain", 300);
        check("rr_lane_reads", 32'(lane_reads - base), 32'd16);
        bus_rd(4, 8'd16);
        bus_rd(5, 8'd0);
        bus_rd(6, 8'd0);
        bus_rd(7, 8'd0);
        bus_rd(8, 8'd0);

        // Fixed priority: lane 0 starves lane 2 until lane 0 drains or is disabled
        do_reset();
        bus_wr(2, 8'd1);
        FIFO_READ = 1'b1;
        for (int k = 0; k < 12; k++) push_lane(0, k);
        for (int k = 0; k < 4; k++)  push_lane(2, k);
        for (int k = 0; k < 12; k++) sb_q.push_back(exp_word(0, k));
        for (int k = 0; k < 4; k++)  sb_q.push_back(exp_word(2, k));
        repeat (3) @(posedge BUS_CLK);
        bus_wr(1, 8'h05);
        wait_drain("fp_drain", 300);
        bus_wr(1, 8'h04);
        for (int k = 12; k < 16; k++) push_lane(0, k);
        for (int k = 4; k < 8; k++)   push_lane(2, k);
        for (int k = 4; k < 8; k++)   sb_q.push_back(exp_word(2, k));
        wait_drain("fp_lane2_drain", 300);
        repeat (5) @(posedge BUS_CLK);
        #1;
        check("fp_lane0_untouched", 32'(ltail[0] - lhead[0]), 32'd4);
        bus_rd(8, 8'h01);

        // Backpressure: one pop then a stable stall
        do_reset();
        FIFO_READ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_lane(1, k);
            sb_q.push_back(exp_word(1, k));
        end
        repeat (3) @(posedge BUS_CLK);
        base = lane_reads;
        bus_wr(1, 8'h02);
        repeat (6) @(posedge BUS_CLK);
        #1;
        check("bp_one_pop", 32'(lane_reads - base), 32'd1);
        check("bp_not_empty", 32'(FIFO_EMPTY), 32'd0);
        check("bp_first_word", FIFO_DATA, 32'h1100_0000);
        held = FIFO_DATA;
        repeat (3) @(posedge BUS_CLK);
        #1;
        check("bp_data_stable", FIFO_DATA, held);
        check("bp_still_one_pop", 32'(lane_reads - base), 32'd1);
        FIFO_READ = 1'b1;
        @(posedge BUS_CLK); #1;
        check("bp_next_word", FIFO_DATA, 32'h1100_0001);
        wait_drain("bp_drain", 100);
        check("bp_total_pops", 32'(lane_reads - base), 32'd3);

        // Error counters: saturation and clear-beats-pulse
        do_reset();
        FIFO_READ = 1'b0;
        @(posedge BUS_CLK); #1;
        LANE_DEC_ERR = 4'b0010;
        repeat (300) @(posedge BUS_CLK);
        #1 LANE_DEC_ERR = '0;
        bus_rd(17, 8'd255);
        bus_rd(16, 8'd0);
        @(posedge BUS_CLK); #1;
        LANE_DEC_ERR = 4'b0010;
        BUS_WR = 1'b1; BUS_ADD = 32'd17; BUS_DATA_IN = 8'h00;
        @(posedge BUS_CLK); #1;
        LANE_DEC_ERR = '0;
        BUS_WR = 1'b0;
        bus_rd(17, 8'd0);
        @(posedge BUS_CLK); #1;
        LANE_DEC_ERR = 4'b0010;
        @(posedge BUS_CLK); #1;
        LANE_DEC_ERR = '0;
        bus_rd(17, 8'd1);
        LANE_LOST_ERR = 4'b1000;
        repeat (5) @(posedge BUS_CLK);
        #1 LANE_LOST_ERR = '0;
        bus_rd(35, 8'd5);
        bus_rd(33, 8'd0);

        // Soft reset while a burst is stalled
        do_reset();
        FIFO_READ = 1'b0;
        for (int k = 0; k < 6; k++) push_lane(0, k);
        repeat (3) @(posedge BUS_CLK);
        base = lane_reads;
        bus_wr(1, 8'h01);
        repeat (5) @(posedge BUS_CLK);
        #1;
        check("sr_pre_loaded", 32'(FIFO_EMPTY), 32'd0);
        check("sr_pre_pops", 32'(lane_reads - base), 32'd1);
        bus_wr(0, 8'h00);
        #1;
        check("sr_fifo_empty", 32'(FIFO_EMPTY), 32'd1);
        check("sr_fifo_data", FIFO_DATA, 32'd0);
        bus_rd(1, 8'h00);
        repeat (10) @(posedge BUS_CLK);
        #1;
        check("sr_no_more_pops", 32'(lane_reads - base), 32'd1);
        check("sr_lane0_left", 32'(ltail[0] - lhead[0]), 32'd5);
        bus_rd(3, 8'd8);

        repeat (4) @(posedge BUS_CLK);
        #1;
        check("sb_leftover", sb_q.size(), 0);
        check("bus_leftover", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tjmono2_rx_arbiter.md
TJMONO2_RX_ARBITER -- requirements
Module: tjmono2_rx_arbiter

Interface
REQ-001 SHALL have parameter NLANES, default 4, meaning the number of receiver lanes merged (range 1..8).
REQ-002 SHALL have parameter ABUSWIDTH, default 32, meaning the bus address width.
REQ-003 SHALL have parameter DATA_IDENTIFIER, default 0, meaning the 4-bit base identifier; lane i tags its words with (DATA_IDENTIFIER+i) mod 16.
REQ-004 SHALL have parameter VERSION, default 2, meaning the value read back at address 0.
REQ-005 SHALL have port BUS_CLK  in  1  single clock; all logic runs on it.
REQ-006 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-007 SHALL have ports BUS_ADD in ABUSWIDTH, BUS_DATA_IN in 8, BUS_DATA_OUT out 8 (registered), BUS_WR in 1, BUS_RD in 1: the register bus.
REQ-008 SHALL have ports LANE_DATA in NLANES*28 (lane i at bits 28i+27:28i) and LANE_EMPTY in NLANES: first-word-fall-through lane FIFOs.
REQ-009 SHALL have port LANE_READ  out  NLANES, a one-hot pop strobe.
REQ-010 SHALL have ports LANE_DEC_ERR in NLANES and LANE_LOST_ERR in NLANES: one-cycle error pulses.
REQ-011 SHALL have ports FIFO_DATA out 32, FIFO_EMPTY out 1 and FIFO_READ in 1: the merged output.

Function
REQ-012 SHALL assert internal reset on RST, or on a BUS_WR to address 0 in the same cycle.
REQ-013 SHALL implement this register map:
- 0: read VERSION.
- 1: LANE_EN mask, reset 0.
- 2: MODE; bit0 0 = round-robin, 1 = fixed priority (lane 0 highest); reset 0.
- 3: BURST limit, reset 8; a value of 0 acts as 1.
- 4..7: forwarded-word counter bytes 0..3.
- 8: read-only lane-not-empty mask (~LANE_EMPTY).
- 16+i: decoder error count of lane i.
- 32+i: lost error count of lane i.
- Any other address reads 0.
REQ-014 SHALL return BUS_DATA_OUT one cycle after BUS_RD.
REQ-015 SHALL snapshot the 32-bit word counter into a buffer when address 4 is read; addresses 5..7 return the buffered bytes.
REQ-016 SHALL increment the word counter once per word accepted into the output register; it wraps from 0xFFFFFFFF to 0.
REQ-017 SHALL implement 8-bit saturating error counters per lane (stop at 255); a BUS_WR to the counter's address clears it, and the clear wins over a simultaneous pulse.
REQ-018 SHALL define a lane as eligible when LANE_EN[i]=1 and LANE_EMPTY[i]=0.
REQ-019 SHALL implement FSM states IDLE and GRANT.
- IDLE -> GRANT when any lane is eligible; the selected lane is latched and no word is popped in the IDLE cycle.
REQ-020 SHALL select the lane as follows:
- Round-robin: search starts at (last_granted+1) mod NLANES.
- Fixed priority: lowest eligible index.
- Reset last_granted = NLANES-1.
REQ-021 SHALL, in GRANT, pulse LANE_READ[g] in a cycle if lane g is eligible and (FIFO_EMPTY=1 or FIFO_READ=1).
REQ-022 SHALL load FIFO_DATA = {(DATA_IDENTIFIER+g)[3:0], LANE_DATA[g]} and set FIFO_EMPTY=0 on that same edge.
REQ-023 SHALL return GRANT -> IDLE when burst count reaches BURST, lane g goes empty, or LANE_EN[g] is cleared; the burst count resets on entering GRANT.
REQ-024 SHALL, on FIFO_READ with FIFO_EMPTY=0 and no new load, set FIFO_EMPTY=1; FIFO_READ while empty is ignored.
REQ-025 SHALL sustain throughput of 1 word/cycle within a burst when FIFO_READ is held high.
REQ-026 SHALL NOT pop a disabled lane, and SHALL NOT assert more than one LANE_READ bit per cycle.

Reset
REQ-027 SHALL, on reset: FSM=IDLE, FIFO_EMPTY=1, FIFO_DATA=0, LANE_READ=0, counters=0, registers at the values in REQ-013, BUS_DATA_OUT=0.
REQ-028 SHALL, on reset mid-burst, discard the pending output word and not pop any lane in the reset cycle.

Verification
REQ-029 Reset value check: RST, then read addresses 0,1,2,3 -> 0x02,0x00,0x00,0x08; FIFO_EMPTY=1.
REQ-030 Round-robin, fairness: NLANES=4, LANE_EN=0x0F, all lanes hold 4 words, BURST=2, FIFO_READ held high -> output identifiers 0,0,1,1,2,2,3,3,0,0,...; word counter=16.
REQ-031 Fixed priority, starvation: MODE=1, lanes 0 and 2 always non-empty -> only lane 0 words are output; clearing LANE_EN bit0 -> lane 2 is served.
REQ-032 Backpressure: FIFO_READ=0 after first word -> exactly 1 LANE_READ pulse and FIFO_DATA stable; FIFO_READ=1 -> next word on the following cycle.
REQ-033 Error counters: 300 LANE_DEC_ERR pulses on lane 1 -> address 17 reads 255; write address 17 during a pulse -> reads 0.
REQ-034 Soft reset mid-burst: write address 0 during GRANT -> FIFO_EMPTY=1, LANE_EN=0, and no further LANE_READ pulses.
